// File: rtl/norm_pkg.sv
// Shared types and default sizes for the frame normalisation path
// (sequencer, min/max scanner and the data_normalizer instance).
package norm_pkg;

  localparam int DEF_DATAW    = 16;
  localparam int DEF_MAX_ADDR = 63;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_START,
    S_NORM,
    S_DONE
  } t_seq_states;

  typedef struct packed {
    logic signed [DEF_DATAW-1:0] min;
    logic        [DEF_DATAW-1:0] range;
  } t_norm_cfg;

endpackage

// File: rtl/frame_minmax.sv
// Streaming signed min/max tracker. o_min/o_max already include the word
// presented this cycle, so the consumer can latch the result alongside o_done.
module frame_minmax
  import norm_pkg::*;
#(
  parameter int DATAW = DEF_DATAW
) (
  input  logic                    i_clk,
  input  logic                    i_valid,
  input  logic                    i_first,
  input  logic                    i_last,
  input  logic signed [DATAW-1:0] i_data,
  output logic signed [DATAW-1:0] o_min,
  output logic signed [DATAW-1:0] o_max,
  output logic                    o_done
);

  logic signed [DATAW-1:0] r_min_p1;
  logic signed [DATAW-1:0] r_max_p1;

  always_comb begin
    o_min = r_min_p1;
    o_max = r_max_p1;
    if (i_valid) begin
      if (i_first || (i_data < r_min_p1)) o_min = i_data;
      if (i_first || (i_data > r_max_p1)) o_max = i_data;
    end
  end

  assign o_done = i_valid & i_last;

  // p1: running extremes; the first word of a frame overwrites both
  always_ff @(posedge i_clk) begin
    r_min_p1 <= o_min;
    r_max_p1 <= o_max;
  end

endmodule

// File: rtl/normalize_sequencer.sv
// Frame controller: scans frame memory for signed min/max, then starts the
// normalizer and hands it the single memory read port until the frame is written.
module normalize_sequencer
  import norm_pkg::*;
#(
  parameter int DATAW    = DEF_DATAW,
  parameter int MAX_ADDR = DEF_MAX_ADDR,
  parameter int ADDRW    = $clog2(MAX_ADDR + 1),
  parameter int TIMEOUT  = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_frame_ready,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic                    o_mem_rd_valid,
  output logic [ADDRW-1:0]        o_mem_rd_addr,
  input  logic signed [DATAW-1:0] i_mem_rd_data,
  output logic                    o_norm_start,
  output logic [DATAW-1:0]        o_norm_min,
  output logic [DATAW-1:0]        o_norm_range,
  input  logic                    i_norm_rd_valid,
  input  logic [ADDRW-1:0]        i_norm_rd_addr,
  output logic [DATAW-1:0]        o_norm_rd_data,
  input  logic                    i_norm_wr_valid,
  input  logic [ADDRW-1:0]        i_norm_wr_addr,
  output logic [7:0]              o_drop_count,
  output logic                    o_err_timeout,
  output logic                    o_err_conflict
);

  localparam int               CNTW      = $clog2(TIMEOUT + 1);
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(MAX_ADDR);
  localparam logic [CNTW-1:0]  TMO_LAST  = CNTW'(TIMEOUT - 1);

  // The widened difference is an unsigned magnitude; clamp anything past DATAW bits.
  function automatic logic [DATAW-1:0] sat_range(input logic [DATAW:0] diff);
    if (diff[DATAW]) return '1;
    return diff[DATAW-1:0];
  endfunction

  t_seq_states             r_state;
  t_seq_states             w_state_nxt;
  logic [ADDRW-1:0]        r_scan_addr;
  logic                    r_vld_p1;
  logic                    r_first_p1;
  logic                    r_last_p1;
  logic [CNTW-1:0]         r_tmo_cnt;
  logic signed [DATAW-1:0] r_norm_min;
  logic [DATAW-1:0]        r_norm_range;
  logic [7:0]              r_drop_cnt;
  logic                    r_err_tmo;
  logic                    r_err_conf;

  logic signed [DATAW-1:0] w_mm_min;
  logic signed [DATAW-1:0] w_mm_max;
  logic                    w_mm_done;
  logic [DATAW:0]          w_diff;
  logic                    w_last_wr;
  logic                    w_tmo_hit;

  frame_minmax #(
    .DATAW (DATAW)
  ) u_minmax (
    .i_clk   (i_clk),
    .i_valid (r_vld_p1),
    .i_first (r_first_p1),
    .i_last  (r_last_p1),
    .i_data  (i_mem_rd_data),
    .o_min   (w_mm_min),
    .o_max   (w_mm_max),
    .o_done  (w_mm_done)
  );

  assign w_diff    = {w_mm_max[DATAW-1], w_mm_max} - {w_mm_min[DATAW-1], w_mm_min};
  assign w_last_wr = i_norm_wr_valid && (i_norm_wr_addr == LAST_ADDR);
  assign w_tmo_hit = (r_state == S_NORM) && !w_last_wr && (r_tmo_cnt == TMO_LAST);

  always_comb begin
    w_state_nxt    = r_state;
    o_mem_rd_valid = 1'b0;
    o_mem_rd_addr  = '0;
    case (r_state)
      S_IDLE:  if (i_frame_ready) w_state_nxt = S_SCAN;
      S_SCAN: begin
        o_mem_rd_valid = 1'b1;
        o_mem_rd_addr  = r_scan_addr;
        if (r_scan_addr == LAST_ADDR) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: w_state_nxt = S_START;
      S_START: w_state_nxt = S_NORM;
      S_NORM: begin
        o_mem_rd_valid = i_norm_rd_valid;
        o_mem_rd_addr  = i_norm_rd_addr;
        if (w_last_wr)      w_state_nxt = S_DONE;
        else if (w_tmo_hit) w_state_nxt = S_IDLE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_busy         = (r_state != S_IDLE);
  assign o_norm_start   = (r_state == S_START);
  assign o_frame_done   = (r_state == S_DONE);
  assign o_norm_rd_data = i_mem_rd_data;
  assign o_norm_min     = r_norm_min;
  assign o_norm_range   = r_norm_range;
  assign o_drop_count   = r_drop_cnt;
  assign o_err_timeout  = r_err_tmo;
  assign o_err_conflict = r_err_conf;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_scan_addr <= '0;
      r_vld_p1    <= 1'b0;
      r_first_p1  <= 1'b0;
      r_last_p1   <= 1'b0;
      r_tmo_cnt   <= '0;
      r_drop_cnt  <= '0;
      r_err_tmo   <= 1'b0;
      r_err_conf  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_scan_addr <= ((r_state == S_SCAN) && (r_scan_addr != LAST_ADDR))
                     ? r_scan_addr + ADDRW'(1) : '0;
      // p1: tags the read data returning one cycle after each scan request
      r_vld_p1    <= (r_state == S_SCAN);
      r_first_p1  <= (r_state == S_SCAN) && (r_scan_addr == '0);
      r_last_p1   <= (r_state == S_SCAN) && (r_scan_addr == LAST_ADDR);
      if (r_state == S_START)     r_tmo_cnt <= '0;
      else if (r_state == S_NORM) r_tmo_cnt <= r_tmo_cnt + CNTW'(1);
      if (i_frame_ready && (r_state != S_IDLE) && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;
      if (w_tmo_hit) r_err_tmo <= 1'b1;
      // The normalizer may pre-assert its first read while start is pulsing
      if (i_norm_rd_valid && (r_state != S_NORM) && (r_state != S_START))
        r_err_conf <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_norm_min   <= '0;
      r_norm_range <= '0;
    end else if ((r_state == S_DRAIN) && w_mm_done) begin
      r_norm_min   <= w_mm_min;
      r_norm_range <= sat_range(w_diff);
    end
  end

endmodule

// File: tb/tb_normalize_sequencer.sv
// Directed bench for normalize_sequencer: ramp, constant and extreme frames,
// dropped frames, normalizer timeout, async reset mid-scan and port conflicts.
module tb_normalize_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fr;
  logic        busy, frame_done, mem_rd_valid, norm_start;
  logic [5:0]  mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic [15:0] norm_min, norm_range, norm_rd_data;
  logic        nrd_valid, nwr_valid;
  logic [5:0]  nrd_addr, nwr_addr;
  logic [7:0]  drop_count;
  logic        err_timeout, err_conflict;

  logic [15:0] mem [0:63];

  int n_tests = 0;
  int n_fail  = 0;
  int lat, nd, n;
  logic seen_done;

  always #5 clk = ~clk;

  always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

  normalize_sequencer dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_frame_ready   (fr),
    .o_busy          (busy),
    .o_frame_done    (frame_done),
    .o_mem_rd_valid  (mem_rd_valid),
    .o_mem_rd_addr   (mem_rd_addr),
    .i_mem_rd_data   (mem_rd_data),
    .o_norm_start    (norm_start),
    .o_norm_min      (norm_min),
    .o_norm_range    (norm_range),
    .i_norm_rd_valid (nrd_valid),
    .i_norm_rd_addr  (nrd_addr),
    .o_norm_rd_data  (norm_rd_data),
    .i_norm_wr_valid (nwr_valid),
    .i_norm_wr_addr  (nwr_addr),
    .o_drop_count    (drop_count),
    .o_err_timeout   (err_timeout),
    .o_err_conflict  (err_conflict)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the start pulse.
  task automatic run_to_start(output int cycles, input int drop_at);
    fr = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      fr = (cycles == drop_at);
    end while (!norm_start && cycles < 200);
    fr = 1'b0;
  endtask

  // Called at a negedge in NORM; writes the last address and counts done pulses.
  task automatic finish_norm(output int ndone);
    ndone = 0;
    nwr_valid = 1'b1;
    nwr_addr  = 6'd63;
    @(negedge clk);
    nwr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (frame_done) ndone++;
      @(negedge clk);
    end
  endtask

  task automatic fill_ramp();
    for (int a = 0; a < 64; a++) mem[a] = 16'(a - 20);
  endtask

  initial begin
    rst = 1'b1; fr = 1'b0;
    nrd_valid = 1'b0; nrd_addr = '0; nwr_valid = 1'b0; nwr_addr = '0;
    for (int a = 0; a < 64; a++) mem[a] = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_min", norm_min, 0);
    check_eq("rst_range", norm_range, 0);
    check_eq("rst_drop", drop_count, 0);
    check_eq("rst_errs", {err_timeout, err_conflict}, 0);
    check_eq("rst_outs", {frame_done, norm_start, mem_rd_valid}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Ramp frame, with a normalizer read raised during the start cycle
    fill_ramp();
    run_to_start(lat, 0);
    check_eq("ramp_lat", lat, 66);
    check_eq("ramp_min", norm_min, 16'hFFEC);
    check_eq("ramp_range", norm_range, 63);
    check_eq("ramp_busy", busy, 1);
    nrd_valid = 1'b1; nrd_addr = 6'd5;
    #1 check_eq("start_blocked", mem_rd_valid, 0);
    @(negedge clk);
    check_eq("start_one_cycle", norm_start, 0);
    check_eq("norm_mux_vld", mem_rd_valid, 1);
    check_eq("norm_mux_addr", mem_rd_addr, 5);
    check_eq("start_no_conflict", err_conflict, 0);
    @(negedge clk);
    check_eq("norm_rd_data", norm_rd_data, 16'hFFF1);
    nrd_valid = 1'b0;
    finish_norm(nd);
    check_eq("ramp_done_pulses", nd, 1);
    check_eq("ramp_idle", busy, 0);

    // Constant frame still issues a start with zero range
    for (int a = 0; a < 64; a++) mem[a] = 16'h0100;
    run_to_start(lat, 0);
    check_eq("const_lat", lat, 66);
    check_eq("const_min", norm_min, 16'h0100);
    check_eq("const_range", norm_range, 0);
    @(negedge clk);
    finish_norm(nd);
    check_eq("const_done_pulses", nd, 1);

    // Extreme pixels, one drop during SCAN and two during NORM
    for (int a = 0; a < 64; a++) mem[a] = '0;
    mem[10] = 16'h8000;
    mem[40] = 16'h7FFF;
    run_to_start(lat, 10);
    check_eq("ext_lat", lat, 66);
    check_eq("ext_min", norm_min, 16'h8000);
    check_eq("ext_range", norm_range, 16'hFFFF);
    @(negedge clk);
    fr = 1'b1; @(negedge clk);
    fr = 1'b0; @(negedge clk);
    fr = 1'b1; @(negedge clk);
    fr = 1'b0;
    check_eq("drop_count", drop_count, 3);
    finish_norm(nd);
    check_eq("ext_done_pulses", nd, 1);
    run_to_start(lat, 0);
    check_eq("after_drop_lat", lat, 66);
    check_eq("after_drop_count", drop_count, 3);
    @(negedge clk);
    finish_norm(nd);
    check_eq("after_drop_done", nd, 1);

    // Normalizer never finishes
    fill_ramp();
    run_to_start(lat, 0);
    n = 0;
    seen_done = 1'b0;
    do begin
      @(negedge clk);
      n++;
      seen_done |= frame_done;
    end while (!err_timeout && n < 1200);
    check_eq("tmo_cycles", n, 1025);
    check_eq("tmo_idle", busy, 0);
    check_eq("tmo_no_done", seen_done, 0);
    run_to_start(lat, 0);
    check_eq("tmo_next_lat", lat, 66);
    check_eq("tmo_next_min", norm_min, 16'hFFEC);
    @(negedge clk);
    finish_norm(nd);
    check_eq("tmo_next_done", nd, 1);
    check_eq("tmo_sticky", err_timeout, 1);

    // Asynchronous reset in the middle of a scan
    fr = 1'b1;
    @(negedge clk);
    fr = 1'b0;
    n = 0;
    while (mem_rd_addr != 6'd30 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("scan_reached_30", {mem_rd_valid, mem_rd_addr}, {1'b1, 6'd30});
    #2 rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_rd_valid", mem_rd_valid, 0);
    check_eq("arst_min_range", {norm_min, norm_range}, 0);
    check_eq("arst_drop", drop_count, 0);
    check_eq("arst_tmo", err_timeout, 0);
    @(negedge clk);
    rst = 1'b0;
    nrd_valid = 1'b1; nrd_addr = 6'd7;
    #1 check_eq("idle_blocked", mem_rd_valid, 0);
    @(negedge clk);
    check_eq("idle_conflict", err_conflict, 1);
    nrd_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
